// File: rtl/dmem_access_unit.sv
// Bridges the MEM stage's single-cycle load/store signals onto a req/ack data bus,
// stalling the pipeline until completion and latching the first access error.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren_i,
    input  logic        mem_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_dout_i,
    output logic [31:0] mem_din_o,
    output logic        mem_stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        err_flag_o,
    output logic [31:0] err_addr_o
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q,     state_d;
    logic                 bus_req_q,   bus_req_d;
    logic                 bus_we_q,    bus_we_d;
    logic [DW-1:0]        bus_addr_q,  bus_addr_d;
    logic [DW-1:0]        bus_wdata_q, bus_wdata_d;
    logic [DW-1:0]        mem_din_q,   mem_din_d;
    logic                 err_flag_q,  err_flag_d;
    logic [DW-1:0]        err_addr_q,  err_addr_d;
    logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;

    logic req_present;
    logic req_bad;

    assign req_present = mem_ren_i | mem_wen_i;
    assign req_bad     = (mem_addr_i[1:0] != 2'b00) | (mem_ren_i & mem_wen_i);

    // Stall is combinational so the request cycle itself freezes the pipeline.
    assign mem_stall_o = ((state_q == IDLE) && req_present) || (state_q == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            mem_din_q   <= '0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mem_din_q   <= mem_din_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_din_d   = mem_din_q;
        err_flag_d  = err_flag_q;
        err_addr_d  = err_addr_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_present) begin
                    if (req_bad) begin
                        // Rejected without touching the bus; only the first error address sticks.
                        mem_din_d  = '0;
                        err_flag_d = 1'b1;
                        if (!err_flag_q) begin
                            err_addr_d = mem_addr_i;
                        end
                        state_d = DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wen_i;
                        bus_addr_d  = {mem_addr_i[DW-1:2], 2'b00};
                        bus_wdata_d = mem_dout_i;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        mem_din_d = bus_rdata_i;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                    bus_req_d  = 1'b0;
                    mem_din_d  = '0;
                    err_flag_d = 1'b1;
                    if (!err_flag_q) begin
                        err_addr_d = bus_addr_q;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign mem_din_o   = mem_din_q;
    assign err_flag_o  = err_flag_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized transaction-level bench for dmem_access_unit with a bus responder
// and an expected-value model of load data and the sticky error state.
module tb_dmem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ren_i, mem_wen_i;
    logic [31:0] mem_addr_i, mem_dout_i, mem_din_o;
    logic        mem_stall_o, bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic        bus_ack_i;
    logic        err_flag_o;
    logic [31:0] err_addr_o;

    dmem_access_unit #(.TIMEOUT(TO), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_ren_i  (mem_ren_i),
        .mem_wen_i  (mem_wen_i),
        .mem_addr_i (mem_addr_i),
        .mem_dout_i (mem_dout_i),
        .mem_din_o  (mem_din_o),
        .mem_stall_o(mem_stall_o),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i  (bus_ack_i),
        .err_flag_o (err_flag_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Expected architectural state seen by the pipeline.
    logic [31:0] exp_din;
    logic        exp_err;
    logic [31:0] exp_err_addr;
    bit          in_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_error(input logic [31:0] a);
        if (!exp_err) begin
            exp_err      = 1'b1;
            exp_err_addr = a;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   32'(bus_req_o),  32'd0);
        check({tag, "_din"},   mem_din_o,       exp_din);
        check({tag, "_err"},   32'(err_flag_o), 32'(exp_err));
        check({tag, "_eaddr"}, err_addr_o,      exp_err_addr);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        bus_ack_i = 1'b0;
    endtask

    // One MEM-stage access; starts at a negedge in IDLE or DONE, ends at the DONE negedge.
    task automatic access(input string tag, input bit ren, input bit wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned delay, input logic [31:0] rdata);
        bit          bad;
        bit          tmo;
        int unsigned nbusy;
        mem_ren_i   = ren;
        mem_wen_i   = wen;
        mem_addr_i  = addr;
        mem_dout_i  = wdata;
        bus_ack_i   = ($urandom_range(0, 3) == 0);
        bus_rdata_i = $urandom();
        if (in_done) begin
            #1 check({tag, "_done_stall"}, 32'(mem_stall_o), 32'd0);
            step();
            bus_ack_i = ($urandom_range(0, 3) == 0);
        end
        #1 check({tag, "_req_stall"}, 32'(mem_stall_o), 32'd1);
        check({tag, "_idle_req"}, 32'(bus_req_o), 32'd0);
        step();
        bad = (addr[1:0] != 2'b00) || (ren && wen);
        if (bad) begin
            exp_din = 32'd0;
            model_error(addr);
        end else begin
            tmo   = (delay >= TO);
            nbusy = tmo ? TO : delay + 1;
            for (int i = 0; i < int'(nbusy); i++) begin
                check({tag, "_busy_req"},   32'(bus_req_o),   32'd1);
                check({tag, "_busy_we"},    32'(bus_we_o),    32'(wen));
                check({tag, "_busy_addr"},  bus_addr_o,       {addr[31:2], 2'b00});
                check({tag, "_busy_wdata"}, bus_wdata_o,      wdata);
                check({tag, "_busy_stall"}, 32'(mem_stall_o), 32'd1);
                bus_ack_i   = !tmo && (i == int'(delay));
                bus_rdata_i = bus_ack_i ? rdata : $urandom();
                step();
            end
            if (tmo) begin
                exp_din = 32'd0;
                model_error({addr[31:2], 2'b00});
            end else if (ren) begin
                exp_din = rdata;
            end
        end
        check({tag, "_done_stall0"}, 32'(mem_stall_o), 32'd0);
        check_quiet({tag, "_done"});
        in_done = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        mem_ren_i  = 1'b0;
        mem_wen_i  = 1'b0;
        mem_addr_i = $urandom();
        mem_dout_i = $urandom();
        for (int i = 0; i < int'(n); i++) begin
            bus_ack_i   = $urandom_range(0, 1) == 1;
            bus_rdata_i = $urandom();
            #1 check("idle_stall", 32'(mem_stall_o), 32'd0);
            step();
        end
        check_quiet("idle");
        in_done = 1'b0;
    endtask

    task automatic do_reset(input bit hold_ren);
        rst_n     = 1'b0;
        mem_ren_i = hold_ren;
        mem_wen_i = 1'b0;
        bus_ack_i = 1'b0;
        step();
        exp_din      = 32'd0;
        exp_err      = 1'b0;
        exp_err_addr = 32'd0;
        in_done      = 1'b0;
        #1 check("rst_stall", 32'(mem_stall_o), 32'(hold_ren));
        check("rst_we",    32'(bus_we_o), 32'd0);
        check("rst_baddr", bus_addr_o,    32'd0);
        check("rst_wdata", bus_wdata_o,   32'd0);
        check_quiet("rst");
        mem_ren_i = 1'b0;
        #1 check("rst_stall_noreq", 32'(mem_stall_o), 32'd0);
        rst_n       = 1'b1;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        step();
        check("stray_ack_stall", 32'(mem_stall_o), 32'd0);
        check_quiet("stray_ack");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ren, wen;
        int unsigned r, delay;
        logic [31:0] addr;
        rst_n       = 1'b0;
        mem_ren_i   = 1'b0;
        mem_wen_i   = 1'b0;
        mem_addr_i  = 32'd0;
        mem_dout_i  = 32'd0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
        in_done     = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        access("zw_load", 1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hCAFE_F00D);
        idle(1);
        access("st_wait3", 1'b0, 1'b1, 32'h24, 32'h1234_5678, 3, 32'h0);
        idle(1);
        access("mis_13", 1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h0);
        idle(1);
        access("mis_21", 1'b0, 1'b1, 32'h21, 32'h5555_AAAA, 0, 32'h0);
        idle(1);
        access("both_rw", 1'b1, 1'b1, 32'h30, 32'h0, 0, 32'h0);
        idle(1);
        access("tmo", 1'b1, 1'b0, 32'h80, 32'h0, TO + 5, 32'h0);
        idle(1);

        // Reset while a read is waiting in its second BUSY cycle.
        mem_ren_i  = 1'b1;
        mem_wen_i  = 1'b0;
        mem_addr_i = 32'h40;
        step();
        check("mb_busy1_req", 32'(bus_req_o), 32'd1);
        step();
        check("mb_busy2_req", 32'(bus_req_o), 32'd1);
        do_reset(1'b1);

        access("b2b_0", 1'b1, 1'b0, 32'h0, 32'h0, 0, 32'h1111_1111);
        access("b2b_1", 1'b1, 1'b0, 32'h4, 32'h0, 0, 32'h2222_2222);
        idle(1);

        for (int k = 0; k < 250; k++) begin
            if (k % 60 == 59) begin
                do_reset(1'b0);
            end
            r    = $urandom_range(0, 9);
            ren  = (r < 5) || (r == 9);
            wen  = (r >= 5);
            addr = $urandom();
            if ($urandom_range(0, 7) != 0) begin
                addr[1:0] = 2'b00;
            end
            delay = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
            access("rnd", ren, wen, addr, $urandom(), delay, $urandom());
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 3));
            end
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
